muldiv_ctrl: RTL and testbench

Sequencing controller between the EX stage and the multiply/divide datapath unit. It owns the architectural HI/LO registers and decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO into handshakes with the multi-cycle mul/div unit. It stalls the pipeline on structural and HI/LO data hazards, and on a pipeline flush it drains and discards any in-flight result.

---
 rtl/muldiv_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencing controller between the EX stage and the
// multi-cycle multiply/divide datapath. Owns the architectural HI/LO
// registers, issues MUL/DIV operations, serves MFHI/MFLO/MTHI/MTLO and
// stalls the pipeline on structural and HI/LO hazards. A flush squashes the
// presented request and drains any in-flight result without committing it.
//
// Optional feature: define MULDIV_ACC_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 9-12), which accumulate the datapath product into {HI,LO}. Without
// the macro those opcodes decode as NOP and no 64-bit adder is built.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src0,
  input  logic [31:0] req_src1,
  output logic        req_ready,
  input  logic        flush,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [31:0] md_src0,
  output logic [31:0] md_src1,
  output logic [1:0]  md_op,
  output logic        md_sign,
  output logic        md_in_valid,
  input  logic        md_in_ready,
  input  logic        md_out_valid,
  output logic        md_out_ready,
  input  logic [31:0] md_res0,
  input  logic [31:0] md_res1
);

  // Request opcodes as presented by the EX stage.
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MULDIV_ACC_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  // Opcode decode results.
  logic is_mul, is_div, is_md;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_nop;

  // Request that is live this cycle: present, not squashed, not in reset.
  logic req_live;

  // 64-bit value committed to {HI,LO} when a result is consumed.
  logic [63:0] commit_val;

`ifdef MULDIV_ACC_EN
  logic op_acc, op_sub;
  logic acc_reg, acc_next;
  logic sub_reg, sub_next;
`endif

  // Operands go straight through to the datapath; it only samples them on issue.
  assign md_src0 = req_src0;
  assign md_src1 = req_src1;

  assign busy     = (state_reg != IDLE);
  assign req_live = req_valid & ~flush & reset;

  // Decode the presented opcode into class flags, datapath op and signedness.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    md_sign = 1'b0;
`ifdef MULDIV_ACC_EN
    op_acc  = 1'b0;
    op_sub  = 1'b0;
`endif
    case (req_op)
      OP_MULT:  begin is_mul = 1'b1; md_sign = 1'b1; end
      OP_MULTU: begin is_mul = 1'b1; end
      OP_DIV:   begin is_div = 1'b1; md_sign = 1'b1; end
      OP_DIVU:  begin is_div = 1'b1; end
      OP_MFHI:  begin is_mfhi = 1'b1; end
      OP_MFLO:  begin is_mflo = 1'b1; end
      OP_MTHI:  begin is_mthi = 1'b1; end
      OP_MTLO:  begin is_mtlo = 1'b1; end
`ifdef MULDIV_ACC_EN
      OP_MADD:  begin is_mul = 1'b1; md_sign = 1'b1; op_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; op_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; md_sign = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default:  ;
    endcase
    md_op  = {is_div, is_mul};
    is_md  = is_mul | is_div;
    is_nop = ~(is_md | is_mfhi | is_mflo | is_mthi | is_mtlo);
  end

  // Value written to {HI,LO} when a result is consumed: plain product/quotient,
  // or the product accumulated into the HI/LO contents at result time.
  always_comb begin
`ifdef MULDIV_ACC_EN
    if (acc_reg) begin
      if (sub_reg) commit_val = {hi_reg, lo_reg} - {md_res1, md_res0};
      else         commit_val = {hi_reg, lo_reg} + {md_res1, md_res0};
    end else begin
      commit_val = {md_res1, md_res0};
    end
`else
    commit_val = {md_res1, md_res0};
`endif
  end

  // Next-state, HI/LO update and handshake outputs.
  always_comb begin
    state_next   = state_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    req_ready    = 1'b1;
    rd_data      = 32'd0;
    md_in_valid  = 1'b0;
    md_out_ready = 1'b0;
`ifdef MULDIV_ACC_EN
    acc_next     = acc_reg;
    sub_next     = sub_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (req_live) begin
          if (is_md) begin
            // Issue and acceptance happen together; stall until the datapath takes it.
            md_in_valid = 1'b1;
            req_ready   = md_in_ready;
            if (md_in_ready) begin
              state_next = BUSY;
`ifdef MULDIV_ACC_EN
              acc_next   = op_acc;
              sub_next   = op_sub;
`endif
            end
          end else if (is_mfhi) begin
            rd_data = hi_reg;
          end else if (is_mflo) begin
            rd_data = lo_reg;
          end else if (is_mthi) begin
            hi_next = req_src0;
          end else if (is_mtlo) begin
            lo_next = req_src0;
          end
        end
      end
      BUSY: begin
        md_out_ready = 1'b1;
        // Every HI/LO access and every new MUL/DIV waits for the result.
        if (req_live && !is_nop) req_ready = 1'b0;
        if (md_out_valid) begin
          state_next = IDLE;
          if (!flush) begin
            hi_next = commit_val[63:32];
            lo_next = commit_val[31:0];
          end
        end else if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Squashed operation still owns the datapath; swallow its result.
        md_out_ready = 1'b1;
        if (req_live && !is_nop) req_ready = 1'b0;
        if (md_out_valid) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
`ifdef MULDIV_ACC_EN
      acc_reg   <= 1'b0;
      sub_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
`ifdef MULDIV_ACC_EN
      acc_reg   <= acc_next;
      sub_reg   <= sub_next;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed test of muldiv_ctrl. The bench plays the role of
// both the EX stage and the mul/div datapath, driving results by hand.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src0;
  logic [31:0] req_src1;
  logic        req_ready;
  logic        flush;
  logic [31:0] rd_data;
  logic        busy;
  logic [31:0] md_src0;
  logic [31:0] md_src1;
  logic [1:0]  md_op;
  logic        md_sign;
  logic        md_in_valid;
  logic        md_in_ready;
  logic        md_out_valid;
  logic        md_out_ready;
  logic [31:0] md_res0;
  logic [31:0] md_res1;

  int checks = 0;
  int errors = 0;
  int issue_count = 0;

  muldiv_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_src0     (req_src0),
    .req_src1     (req_src1),
    .req_ready    (req_ready),
    .flush        (flush),
    .rd_data      (rd_data),
    .busy         (busy),
    .md_src0      (md_src0),
    .md_src1      (md_src1),
    .md_op        (md_op),
    .md_sign      (md_sign),
    .md_in_valid  (md_in_valid),
    .md_in_ready  (md_in_ready),
    .md_out_valid (md_out_valid),
    .md_out_ready (md_out_ready),
    .md_res0      (md_res0),
    .md_res1      (md_res1)
  );

  always #5 clk = ~clk;

  // Count issue handshakes seen by the datapath.
  always @(posedge clk) begin
    if (md_in_valid && md_in_ready) issue_count <= issue_count + 1;
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid    = 1'b0;
    req_op       = 4'd0;
    req_src0     = 32'd0;
    req_src1     = 32'd0;
    flush        = 1'b0;
    md_in_ready  = 1'b0;
    md_out_valid = 1'b0;
    md_res0      = 32'd0;
    md_res1      = 32'd0;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] s0, input logic [31:0] s1);
    req_valid = 1'b1;
    req_op    = op;
    req_src0  = s0;
    req_src1  = s1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    present(4'd1, 32'h1234, 32'h5678);
    md_in_ready = 1'b1;
    #2;
    checks++; if (md_in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid got %b exp 0", md_in_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (md_out_ready !== 1'b0) begin errors++; $display("FAIL reset_out_ready got %b exp 0", md_out_ready); end
    cyc();
    cyc();
    drive_idle();
    reset = 1'b1;
    cyc();
    present(4'd5, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", rd_data); end
    $display("test_reset done");
  endtask

  task automatic test_mult();
    cyc();
    drive_idle();
    present(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    md_in_ready = 1'b1;
    #1;
    checks++; if (md_in_valid !== 1'b1) begin errors++; $display("FAIL mult_issue got %b exp 1", md_in_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mult_accept got %b exp 1", req_ready); end
    checks++; if (md_op !== 2'b01) begin errors++; $display("FAIL mult_op got %b exp 01", md_op); end
    checks++; if (md_sign !== 1'b1) begin errors++; $display("FAIL mult_sign got %b exp 1", md_sign); end
    checks++; if (md_src0 !== 32'hFFFF_FFFF || md_src1 !== 32'h2) begin errors++; $display("FAIL mult_src got %h %h exp ffffffff 00000002", md_src0, md_src1); end
    cyc();
    md_in_ready = 1'b0;
    present(4'd5, 32'd0, 32'd0);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy got %b exp 1", busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mult_mfhi_stall got %b exp 0", req_ready); end
    checks++; if (md_out_ready !== 1'b1) begin errors++; $display("FAIL mult_out_ready got %b exp 1", md_out_ready); end
    checks++; if (md_in_valid !== 1'b0) begin errors++; $display("FAIL mult_busy_in_valid got %b exp 0", md_in_valid); end
    cyc();
    md_out_valid = 1'b1;
    md_res1 = 32'hFFFF_FFFF;
    md_res0 = 32'hFFFF_FFFE;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mult_result_cycle_stall got %b exp 0", req_ready); end
    cyc();
    md_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_idle got %b exp 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mult_mfhi_ready got %b exp 1", req_ready); end
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", rd_data); end
    cyc();
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h exp fffffffe", rd_data); end
    $display("test_mult done");
  endtask

  task automatic test_divu();
    cyc();
    drive_idle();
    present(4'd4, 32'd100, 32'd7);
    md_in_ready = 1'b1;
    #1;
    checks++; if (md_op !== 2'b10) begin errors++; $display("FAIL divu_op got %b exp 10", md_op); end
    checks++; if (md_sign !== 1'b0) begin errors++; $display("FAIL divu_sign got %b exp 0", md_sign); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL divu_accept got %b exp 1", req_ready); end
    cyc();
    md_in_ready = 1'b0;
    present(4'd6, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL divu_mflo_stall got %b exp 0", req_ready); end
      cyc();
    end
    md_out_valid = 1'b1;
    md_res0 = 32'd14;
    md_res1 = 32'd2;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL divu_result_stall got %b exp 0", req_ready); end
    cyc();
    md_out_valid = 1'b0;
    md_res0 = 32'hBAD0_BAD0;
    #1;
    checks++; if (req_ready !== 1'b1 || rd_data !== 32'd14) begin errors++; $display("FAIL divu_lo got %b/%h exp 1/0000000e", req_ready, rd_data); end
    cyc();
    present(4'd5, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", rd_data); end
    $display("test_divu done");
  endtask

  task automatic test_acc();
    cyc();
    drive_idle();
    present(4'd8, 32'h5, 32'd0);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mtlo_ready got %b exp 1", req_ready); end
    cyc();
    present(4'd7, 32'h0, 32'd0);
    cyc();
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'h5) begin errors++; $display("FAIL mtlo_value got %h exp 00000005", rd_data); end
`ifdef MULDIV_ACC_EN
    cyc();
    present(4'd9, 32'd3, 32'd4);
    md_in_ready = 1'b1;
    #1;
    checks++; if (md_in_valid !== 1'b1 || md_op !== 2'b01 || md_sign !== 1'b1) begin errors++; $display("FAIL madd_issue got %b %b %b exp 1 01 1", md_in_valid, md_op, md_sign); end
    cyc();
    drive_idle();
    md_out_valid = 1'b1;
    md_res0 = 32'd12;
    cyc();
    drive_idle();
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'h11) begin errors++; $display("FAIL madd_lo got %h exp 00000011", rd_data); end
    cyc();
    present(4'd5, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL madd_hi got %h exp 00000000", rd_data); end
    cyc();
    present(4'd11, 32'd3, 32'd4);
    md_in_ready = 1'b1;
    cyc();
    drive_idle();
    md_out_valid = 1'b1;
    md_res0 = 32'd12;
    cyc();
    drive_idle();
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'h5) begin errors++; $display("FAIL msub_lo got %h exp 00000005", rd_data); end
`else
    cyc();
    present(4'd9, 32'd3, 32'd4);
    md_in_ready = 1'b1;
    #1;
    checks++; if (md_in_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL madd_nop got %b/%b exp 0/1", md_in_valid, req_ready); end
    cyc();
    drive_idle();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL madd_nop_busy got %b exp 0", busy); end
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'h5) begin errors++; $display("FAIL madd_nop_lo got %h exp 00000005", rd_data); end
`endif
    $display("test_acc done");
  endtask

  task automatic test_flush();
    // Flush in IDLE: MTLO and MULT both squashed.
    cyc();
    drive_idle();
    present(4'd8, 32'hAAAA, 32'd0);
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready got %b exp 1", req_ready); end
    cyc();
    present(4'd1, 32'd3, 32'd3);
    md_in_ready = 1'b1;
    #1;
    checks++; if (md_in_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_issue got %b exp 0", md_in_valid); end
    cyc();
    drive_idle();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b exp 0", busy); end
    // DIV, flush two cycles later, result arrives in DRAIN.
    present(4'd3, 32'd10, 32'd3);
    md_in_ready = 1'b1;
    cyc();
    drive_idle();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (busy !== 1'b1 || md_out_ready !== 1'b1) begin errors++; $display("FAIL drain_state got %b/%b exp 1/1", busy, md_out_ready); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL drain_stall got %b exp 0", req_ready); end
    md_out_valid = 1'b1;
    md_res0 = 32'hDEAD;
    md_res1 = 32'hDEAD;
    cyc();
    md_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL drain_exit got %b/%b exp 0/1", busy, req_ready); end
    checks++; if (rd_data !== 32'h5) begin errors++; $display("FAIL drain_lo got %h exp 00000005", rd_data); end
    cyc();
    present(4'd5, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL drain_hi got %h exp 00000000", rd_data); end
    // Flush coinciding with the result in BUSY: result discarded, straight to IDLE.
    cyc();
    drive_idle();
    present(4'd2, 32'd7, 32'd7);
    md_in_ready = 1'b1;
    cyc();
    drive_idle();
    flush = 1'b1;
    md_out_valid = 1'b1;
    md_res0 = 32'd49;
    cyc();
    drive_idle();
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (busy !== 1'b0 || rd_data !== 32'h5) begin errors++; $display("FAIL flush_result got %b/%h exp 0/00000005", busy, rd_data); end
    $display("test_flush done");
  endtask

  task automatic test_back_to_back();
    int base;
    cyc();
    drive_idle();
    base = issue_count;
    present(4'd1, 32'd6, 32'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0 || md_in_valid !== 1'b1) begin errors++; $display("FAIL in_ready_stall got %b/%b exp 0/1", req_ready, md_in_valid); end
      cyc();
    end
    md_in_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL in_ready_accept got %b exp 1", req_ready); end
    cyc();
    md_in_ready = 1'b1;
    md_out_valid = 1'b1;
    md_res0 = 32'd42;
    #1;
    checks++; if (req_ready !== 1'b0 || md_in_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold got %b/%b exp 0/0", req_ready, md_in_valid); end
    cyc();
    md_out_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || md_in_valid !== 1'b1) begin errors++; $display("FAIL b2b_issue got %b/%b exp 1/1", req_ready, md_in_valid); end
    cyc();
    drive_idle();
    #1;
    checks++; if (issue_count - base !== 2) begin errors++; $display("FAIL issue_count got %0d exp 2", issue_count - base); end
    md_out_valid = 1'b1;
    md_res0 = 32'd42;
    cyc();
    drive_idle();
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'd42) begin errors++; $display("FAIL b2b_lo got %h exp 0000002a", rd_data); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_busy();
    cyc();
    drive_idle();
    present(4'd7, 32'hABCD, 32'd0);
    cyc();
    present(4'd1, 32'd2, 32'd2);
    md_in_ready = 1'b1;
    cyc();
    drive_idle();
    present(4'd5, 32'd0, 32'd0);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rb_busy got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || md_out_ready !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rb_outputs got %b/%b/%b exp 0/0/1", busy, md_out_ready, req_ready); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rb_rd_data got %h exp 0", rd_data); end
    cyc();
    reset = 1'b1;
    cyc();
    #1;
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rb_hi got %h exp 00000000", rd_data); end
    cyc();
    present(4'd6, 32'd0, 32'd0);
    #1;
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rb_lo got %h exp 00000000", rd_data); end
    $display("test_reset_busy done");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu();
    test_acc();
    test_flush();
    test_back_to_back();
    test_reset_busy();
    cyc();
    drive_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
